// File: rtl/cache_line_fill_ctrl_if.sv
// Miss/bus signal bundle between the fill controller and its tag, replacement and bus neighbours.
// Optional CritWordReady exists only when CACHE_CRITICAL_WORD_FIRST_EN is defined.
interface cache_line_fill_ctrl_if #(
  parameter int NUMWAYS  = 4,
  parameter int SETLEN   = 9,
  parameter int BEATS    = 8,
  parameter int LOGBEATS = $clog2(BEATS)
);
  logic                MissReq;
  logic                FlushStage;
  logic [SETLEN-1:0]   MissSet;
  logic [LOGBEATS-1:0] MissWord;
  logic [NUMWAYS-1:0]  VictimWay;
  logic                VictimDirty;
  logic                BusReady;
  logic                BusReq;
  logic                BusWrite;
  logic [LOGBEATS-1:0] BeatIdx;
  logic [NUMWAYS-1:0]  FillWay;
  logic [SETLEN-1:0]   FillSet;
  logic                DataWriteEn;
  logic                SetValid;
  logic                LRUWriteEn;
  logic                Stall;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  logic                CritWordReady;
`endif

  modport master (
    input  MissReq, FlushStage, MissSet, MissWord, VictimWay, VictimDirty, BusReady,
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    output CritWordReady,
`endif
    output BusReq, BusWrite, BeatIdx, FillWay, FillSet, DataWriteEn, SetValid, LRUWriteEn, Stall
  );

  modport slave (
    output MissReq, FlushStage, MissSet, MissWord, VictimWay, VictimDirty, BusReady,
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    input  CritWordReady,
`endif
    input  BusReq, BusWrite, BeatIdx, FillWay, FillSet, DataWriteEn, SetValid, LRUWriteEn, Stall
  );
endinterface

// File: rtl/cache_line_fill_ctrl.sv
// Cache miss sequencer: optional victim writeback, line fetch, then valid/LRU update pulse.
// CACHE_CRITICAL_WORD_FIRST_EN starts the fetch at the missing word and adds CritWordReady.
module cache_line_fill_ctrl #(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 9,
  parameter int BEATS   = 8,
  localparam int LOGBEATS = $clog2(BEATS)
) (
  input  logic clk,
  input  logic reset,
  cache_line_fill_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, DONE} state_t;

  state_t              state_r, state_s;
  logic [LOGBEATS-1:0] cnt_r, cnt_s;
  logic [LOGBEATS-1:0] rcv_r, rcv_s;
  logic [NUMWAYS-1:0]  way_r, way_s;
  logic [SETLEN-1:0]   set_r, set_s;
  logic [LOGBEATS-1:0] miss_start_s, fetch_start_s;
  logic                accept_s;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  logic [LOGBEATS-1:0] word_r, word_s;
`endif

  assign accept_s = (state_r == IDLE) & bus.MissReq & ~bus.FlushStage;

  // Fetch start word: live MissWord on direct acceptance, latched copy after a writeback.
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign miss_start_s  = bus.MissWord;
  assign fetch_start_s = word_r;
`else
  assign miss_start_s  = {LOGBEATS{1'b0}};
  assign fetch_start_s = {LOGBEATS{1'b0}};
`endif

  // State and latched miss fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {LOGBEATS{1'b0}};
      rcv_r   <= {LOGBEATS{1'b0}};
      way_r   <= {NUMWAYS{1'b0}};
      set_r   <= {SETLEN{1'b0}};
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      word_r  <= {LOGBEATS{1'b0}};
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      rcv_r   <= rcv_s;
      way_r   <= way_s;
      set_r   <= set_s;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      word_r  <= word_s;
`endif
    end
  end

  // Next-state logic; rcv counts fetched beats independently of the wrapping word index.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rcv_s   = rcv_r;
    way_s   = way_r;
    set_s   = set_r;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    word_s  = word_r;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          way_s = bus.VictimWay;
          set_s = bus.MissSet;
          rcv_s = {LOGBEATS{1'b0}};
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
          word_s = bus.MissWord;
`endif
          if (bus.VictimDirty) begin
            state_s = WRITEBACK;
            cnt_s   = {LOGBEATS{1'b0}};
          end else begin
            state_s = FETCH;
            cnt_s   = miss_start_s;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WRITEBACK: begin
        if (bus.BusReady) begin
          if (cnt_r == LOGBEATS'(BEATS - 1)) begin
            state_s = FETCH;
            cnt_s   = fetch_start_s;
          end else begin
            cnt_s   = cnt_r + LOGBEATS'(1);
          end
        end else begin
          state_s = WRITEBACK;
        end
      end
      FETCH: begin
        if (bus.BusReady) begin
          cnt_s = cnt_r + LOGBEATS'(1);
          rcv_s = rcv_r + LOGBEATS'(1);
          if (rcv_r == LOGBEATS'(BEATS - 1)) begin
            state_s = DONE;
          end else begin
            state_s = FETCH;
          end
        end else begin
          state_s = FETCH;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  assign bus.BusReq      = (state_r == WRITEBACK) | (state_r == FETCH);
  assign bus.BusWrite    = (state_r == WRITEBACK);
  assign bus.BeatIdx     = cnt_r;
  assign bus.FillWay     = way_r;
  assign bus.FillSet     = set_r;
  assign bus.DataWriteEn = (state_r == FETCH) & bus.BusReady;
  assign bus.SetValid    = (state_r == DONE);
  assign bus.LRUWriteEn  = (state_r == DONE);
  assign bus.Stall       = accept_s | (state_r != IDLE);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign bus.CritWordReady = (state_r == FETCH) & bus.BusReady & (rcv_r == {LOGBEATS{1'b0}});
`endif

  cache_line_fill_ctrl_chk #(.NUMWAYS(NUMWAYS)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .accept     (accept_s),
    .victim_way (bus.VictimWay)
  );
endmodule

// Victim way must be exactly one-hot whenever a miss is accepted.
module cache_line_fill_ctrl_chk #(
  parameter int NUMWAYS = 4
) (
  input logic               clk,
  input logic               reset,
  input logic               accept,
  input logic [NUMWAYS-1:0] victim_way
);
  a_victim_onehot: assert property (@(posedge clk) disable iff (reset) accept |-> $onehot(victim_way));
endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Scoreboard bench for cache_line_fill_ctrl: expected beats and fill pulses are queued at
// stimulus time and popped by a negedge monitor as the DUT produces them.
module tb_cache_line_fill_ctrl;
  logic clk;
  logic reset;

  cache_line_fill_ctrl_if #(.NUMWAYS(4), .SETLEN(9), .BEATS(8)) bus ();

  cache_line_fill_ctrl #(.NUMWAYS(4), .SETLEN(9), .BEATS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef struct packed {
    logic       wr;
    logic [2:0] idx;
    logic       dwe;
  } beat_t;

  typedef struct packed {
    logic [3:0] way;
    logic [8:0] set;
  } done_t;

  beat_t beat_q[$];
  done_t done_q[$];
  beat_t e;
  done_t d;

  int checks = 0;
  int errors = 0;
  int stall_cnt, fetch_cyc, dwe_cnt, wb_cnt, sv_cnt;
  bit mon_en = 1'b0;
  bit tmode, fmode, tog;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and drive per-cycle inputs shortly after the edge.
  task tick();
    @(posedge clk);
    #1;
    if (tmode) begin
      if (bus.BusReq) begin
        bus.BusReady = tog;
        tog = ~tog;
      end else begin
        bus.BusReady = 1'b0;
      end
    end else begin
      bus.BusReady = 1'b1;
    end
    if (fmode && bus.BusReq) begin
      bus.FlushStage  = 1'b1;
      bus.MissReq     = 1'b1;
      bus.VictimWay   = 4'b1000;
      bus.MissSet     = 9'h155;
      bus.VictimDirty = 1'b1;
    end else begin
      bus.FlushStage = 1'b0;
      bus.MissReq    = 1'b0;
    end
  endtask

  // Negedge monitor: pop and compare against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.Stall) stall_cnt++;
      if (bus.BusReq && !bus.BusWrite) fetch_cyc++;
      if (bus.BusReq) check("dwe_gate", bus.DataWriteEn, ~bus.BusWrite & bus.BusReady);
      if (bus.BusReq && bus.BusReady) begin
        if (beat_q.size() == 0) begin
          check("beat_unexpected", 1, 0);
        end else begin
          e = beat_q.pop_front();
          check("bus_write", bus.BusWrite, e.wr);
          check("beat_idx", bus.BeatIdx, e.idx);
          check("dwe", bus.DataWriteEn, e.dwe);
        end
        if (bus.DataWriteEn) begin
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
          check("crit_word", bus.CritWordReady, dwe_cnt == 0);
`endif
          dwe_cnt++;
        end else begin
          wb_cnt++;
        end
      end
      if (bus.SetValid || bus.LRUWriteEn) begin
        check("lru_pulse", bus.LRUWriteEn, bus.SetValid);
        sv_cnt++;
        if (done_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          d = done_q.pop_front();
          check("fill_way", bus.FillWay, d.way);
          check("fill_set", bus.FillSet, d.set);
        end
      end
    end
  end

  task push_miss(input logic [3:0] way, input logic [8:0] set, input int word,
                 input bit dirty, input int nfetch, input bit with_done);
    int fs;
    fs = CWF ? word : 0;
    if (dirty) begin
      for (int i = 0; i < 8; i++) beat_q.push_back('{wr: 1'b1, idx: 3'(i), dwe: 1'b0});
    end
    for (int i = 0; i < nfetch; i++)
      beat_q.push_back('{wr: 1'b0, idx: 3'((fs + i) % 8), dwe: 1'b1});
    if (with_done) done_q.push_back('{way: way, set: set});
  endtask

  task run_miss(input string name, input logic [3:0] way, input logic [8:0] set, input int word,
                input bit dirty, input bit tm, input bit fm, input int exp_stall, input int exp_fetch);
    int n, sv0;
    tmode = tm;
    fmode = fm;
    tick();
    bus.MissReq     = 1'b1;
    bus.FlushStage  = 1'b0;
    bus.VictimWay   = way;
    bus.MissSet     = set;
    bus.MissWord    = 3'(word);
    bus.VictimDirty = dirty;
    stall_cnt = 0; fetch_cyc = 0; dwe_cnt = 0; wb_cnt = 0; tog = 1'b1;
    sv0 = sv_cnt;
    push_miss(way, set, word, dirty, 8, 1'b1);
    n = 0;
    while (sv_cnt == sv0 && n < 200) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, n < 200, 1);
    tick();
    @(negedge clk);
    check({name, "_stall_drop"}, bus.Stall, 0);
    check({name, "_stall_cycles"}, stall_cnt, exp_stall);
    check({name, "_fetch_cycles"}, fetch_cyc, exp_fetch);
    check({name, "_dwe_count"}, dwe_cnt, 8);
    check({name, "_wb_count"}, wb_cnt, dirty ? 8 : 0);
    check({name, "_sb_empty"}, beat_q.size() + done_q.size(), 0);
    tmode = 1'b0;
    fmode = 1'b0;
  endtask

  initial begin
    int n, sv0;
    reset = 1'b1;
    tmode = 1'b0; fmode = 1'b0; tog = 1'b1;
    stall_cnt = 0; fetch_cyc = 0; dwe_cnt = 0; wb_cnt = 0; sv_cnt = 0;
    bus.MissReq = 1'b0; bus.FlushStage = 1'b0; bus.MissSet = 9'h000; bus.MissWord = 3'd0;
    bus.VictimWay = 4'b0001; bus.VictimDirty = 1'b0; bus.BusReady = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busreq", bus.BusReq, 0);
    check("rst_buswrite", bus.BusWrite, 0);
    check("rst_beatidx", bus.BeatIdx, 0);
    check("rst_fillway", bus.FillWay, 0);
    check("rst_fillset", bus.FillSet, 0);
    check("rst_setvalid", bus.SetValid, 0);
    check("rst_lru", bus.LRUWriteEn, 0);
    check("rst_stall", bus.Stall, 0);
    check("rst_dwe", bus.DataWriteEn, 0);
    mon_en = 1'b1;

    run_miss("clean",  4'b0100, 9'h1A5, 0, 1'b0, 1'b0, 1'b0, 10, 8);
    run_miss("dirty",  4'b0010, 9'h033, 3, 1'b1, 1'b0, 1'b0, 18, 8);
    run_miss("toggle", 4'b1000, 9'h1FF, 0, 1'b0, 1'b1, 1'b0, 17, 15);
    run_miss("flushf", 4'b0001, 9'h000, 0, 1'b0, 1'b0, 1'b1, 10, 8);
    run_miss("critw",  4'b0100, 9'h0AA, 5, 1'b0, 1'b0, 1'b0, 10, 8);

    // Flushed miss in IDLE is dropped.
    tick();
    bus.MissReq = 1'b1; bus.FlushStage = 1'b1; bus.VictimWay = 4'b0010; bus.VictimDirty = 1'b1;
    @(negedge clk);
    check("flush_idle_stall", bus.Stall, 0);
    tick();
    @(negedge clk);
    check("flush_idle_busreq", bus.BusReq, 0);
    check("flush_idle_stall2", bus.Stall, 0);

    // Reset during fetch beat 3 aborts silently.
    tick();
    bus.MissReq = 1'b1; bus.FlushStage = 1'b0; bus.VictimWay = 4'b0001;
    bus.MissSet = 9'h0F0; bus.MissWord = 3'd0; bus.VictimDirty = 1'b0;
    sv0 = sv_cnt;
    push_miss(4'b0001, 9'h0F0, 0, 1'b0, 4, 1'b0);
    n = 0;
    tick();
    while (!(bus.BusReq && !bus.BusWrite && bus.BeatIdx == 3'd3) && n < 50) begin
      tick();
      n++;
    end
    check("rst_mid_reach", n < 50, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_busreq", bus.BusReq, 0);
    check("rst_mid_stall", bus.Stall, 0);
    check("rst_mid_fillway", bus.FillWay, 0);
    repeat (12) tick();
    @(negedge clk);
    check("rst_mid_no_pulse", sv_cnt, sv0);
    check("rst_mid_sb_empty", beat_q.size() + done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
